centroid_tracker: RTL and testbench
===================================

Name: centroid_tracker

Overview:
Streaming object-centroid unit for the tracking pipeline; successor to the fixed 640x480 position measurer. Consumes the raster-ordered delta-frame stream and classifies each pixel as object when pixel_data >= threshold. Per frame it accumulates count, coordinate sums and bounding box, then divides with an iterative divider. Each frame's result is delivered on a valid/ready output so the downstream tracker/overlay can stall.

Parameters:
FRAME_WIDTH, 640, active pixels per line
FRAME_HEIGHT, 480, active lines per frame
COLOR_WIDTH, 10, pixel_data/threshold width
COORD_WIDTH, 11, coordinate width; 2^COORD_WIDTH > max(FRAME_WIDTH, FRAME_HEIGHT)
COUNT_WIDTH, 19, object pixel counter width; 2^COUNT_WIDTH > FRAME_WIDTH*FRAME_HEIGHT
SUM_WIDTH, 30, coordinate-sum width; >= COUNT_WIDTH+COORD_WIDTH
MIN_PIXELS, 16, minimum object count for a valid centroid; >= 1

Ports:
clk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
pixel_valid  in  1  qualifies pixel_data/sof this cycle
sof  in  1  start of frame, meaningful only with pixel_valid
pixel_data  in  COLOR_WIDTH  delta-frame magnitude
threshold  in  COLOR_WIDTH  object threshold, sampled every accepted pixel
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
object_found  out  1  count >= MIN_PIXELS
x_position  out  COORD_WIDTH  floor(x_sum/count)
y_position  out  COORD_WIDTH  floor(y_sum/count)
pixel_count  out  COUNT_WIDTH  object pixels in frame
bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max  out  COORD_WIDTH each  object bounding box
drop_count  out  8  saturating count of frames lost to backpressure
sync_error_count  out  8  saturating count of early sof resyncs

Behaviour:
- Reset: all outputs 0; FSM IDLE; x/y counters 0; accumulators cleared; bbox min regs = all-ones, max regs = 0.
- Counters: x advances on each accepted pixel; at x=FRAME_WIDTH-1 it wraps to 0 and y increments. The last pixel is (FRAME_WIDTH-1, FRAME_HEIGHT-1); after it both counters wrap to 0. No cycles are consumed by blanking.
- sof with pixel_valid when (x,y) != (0,0): discard the partial frame and treat this pixel as (0,0) of a new frame. Increment sync_error_count, saturating at 255. sof at (0,0) is normal and silent.
- Object pixel (accepted and pixel_data >= threshold): count += 1, x_sum += x, y_sum += y, and update bbox min/max. No update when pixel_valid=0.
- End of frame, on the cycle the last pixel is accepted (including its own contribution):
  - Snapshot count, sums and bbox into the result stage.
  - Clear accumulators and bbox for the next frame.
  - Accumulation continues without gaps during the divide (double-buffered).
- Result FSM: IDLE -> DIVIDE -> HOLD -> IDLE.
  - IDLE, snapshot event:
    - count >= MIN_PIXELS: go to DIVIDE.
    - Otherwise go directly to HOLD with object_found=0, x/y=0, bbox=0, pixel_count = snapshot count.
  - DIVIDE: restoring shift-subtract, one quotient bit per cycle, x and y in parallel, SUM_WIDTH cycles. Quotients are truncated to COORD_WIDTH; the result always fits because the mean is <= max coordinate.
  - HOLD: out_valid=1 and all result outputs stable. Transfer when out_valid && out_ready; next cycle out_valid=0 and the FSM returns to IDLE.
  - If the snapshot event and the transfer occur in the same cycle, the new result is taken; no frame is dropped.
- Latency: last pixel accepted at edge N.
  - Found case: out_valid high after edge N+SUM_WIDTH+1.
  - Not-found case: out_valid high after edge N+1.
- Overrun: a snapshot event while the FSM is in DIVIDE, or in HOLD without a same-cycle transfer, discards the new frame. The in-flight result is kept and drop_count increments, saturating at 255.
- out_valid never deasserts without a transfer, except on reset.
- Reset mid-divide or mid-hold: result is lost immediately, out_valid=0, and counters restart at (0,0).
- threshold and pixel_data are unsigned; comparison is >=.

Test Plan:
- Found-object centroid and bbox: FRAME_WIDTH=8, FRAME_HEIGHT=6, MIN_PIXELS=4, SUM_WIDTH=16; object block x=2..5, y=1..3, other pixels 0, threshold=512. Expected: object_found=1, pixel_count=12, x=3, y=2, bbox (2,5,1,3); out_valid exactly SUM_WIDTH+1 cycles after the last pixel.
- Below-minimum frame: 3-pixel object with MIN_PIXELS=4. Expected: object_found=0, x=y=0, pixel_count=3, out_valid one cycle after the last pixel.
- Threshold boundary: pixel_data=threshold counts as object; pixel_data=threshold-1 does not. Check via pixel_count.
- Early sof resync: assert sof at pixel (3,2) mid-frame. Expected: sync_error_count=1 and the next result reflects only pixels from the new sof onward.
- Backpressure and overrun: hold out_ready=0 across two further complete frames. Expected: the first result stays stable, drop_count=2, and after releasing out_ready exactly one transfer occurs.
- Gapped input and reset: apply random pixel_valid gaps and confirm results are identical to the gap-free run. Then assert aresetn low during DIVIDE; expected: all outputs 0 next cycle and correct results for the following full frame.

Source files
------------

// File: rtl/centroid_tracker.sv
// Streaming object-centroid unit: per-frame count, coordinate sums and bounding box,
// followed by a restoring divider and a valid/ready result register.
module centroid_tracker #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int COLOR_WIDTH  = 10,
  parameter int COORD_WIDTH  = 11,
  parameter int COUNT_WIDTH  = 19,
  parameter int SUM_WIDTH    = 30,
  parameter int MIN_PIXELS   = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   pixel_valid,
  input  logic                   sof,
  input  logic [COLOR_WIDTH-1:0] pixel_data,
  input  logic [COLOR_WIDTH-1:0] threshold,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   object_found,
  output logic [COORD_WIDTH-1:0] x_position,
  output logic [COORD_WIDTH-1:0] y_position,
  output logic [COUNT_WIDTH-1:0] pixel_count,
  output logic [COORD_WIDTH-1:0] bbox_x_min,
  output logic [COORD_WIDTH-1:0] bbox_x_max,
  output logic [COORD_WIDTH-1:0] bbox_y_min,
  output logic [COORD_WIDTH-1:0] bbox_y_max,
  output logic [7:0]             drop_count,
  output logic [7:0]             sync_error_count
);
  localparam logic [1:0] IDLE = 2'd0, DIVIDE = 2'd1, HOLD = 2'd2;
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] CMAX   = '1;
  localparam int DCW = $clog2(SUM_WIDTH + 1);

  logic [COORD_WIDTH-1:0] x_cnt, y_cnt, px, py;
  logic                   early_sof, is_obj, last_px;
  logic [COUNT_WIDTH-1:0] acc_cnt, b_cnt, nxt_cnt, snap_cnt;
  logic [SUM_WIDTH-1:0]   acc_xsum, acc_ysum, b_xsum, b_ysum, nxt_xsum, nxt_ysum, snap_xsum, snap_ysum;
  logic [COORD_WIDTH-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [COORD_WIDTH-1:0] b_xmin, b_xmax, b_ymin, b_ymax;
  logic [COORD_WIDTH-1:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
  logic [COORD_WIDTH-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;
  logic                   snap_vld;

  // An early sof restarts the frame at this very pixel, so it sees an empty accumulator.
  always_comb begin
    early_sof = pixel_valid && sof && (x_cnt != '0 || y_cnt != '0);
    px        = early_sof ? '0 : x_cnt;
    py        = early_sof ? '0 : y_cnt;
    is_obj    = pixel_valid && (pixel_data >= threshold);
    last_px   = pixel_valid && (px == X_LAST) && (py == Y_LAST);
    b_cnt     = early_sof ? '0 : acc_cnt;
    b_xsum    = early_sof ? '0 : acc_xsum;
    b_ysum    = early_sof ? '0 : acc_ysum;
    b_xmin    = early_sof ? CMAX : acc_xmin;
    b_xmax    = early_sof ? '0 : acc_xmax;
    b_ymin    = early_sof ? CMAX : acc_ymin;
    b_ymax    = early_sof ? '0 : acc_ymax;
    nxt_cnt   = b_cnt + COUNT_WIDTH'(is_obj);
    nxt_xsum  = b_xsum + (is_obj ? SUM_WIDTH'(px) : '0);
    nxt_ysum  = b_ysum + (is_obj ? SUM_WIDTH'(py) : '0);
    nxt_xmin  = (is_obj && px < b_xmin) ? px : b_xmin;
    nxt_xmax  = (is_obj && px > b_xmax) ? px : b_xmax;
    nxt_ymin  = (is_obj && py < b_ymin) ? py : b_ymin;
    nxt_ymax  = (is_obj && py > b_ymax) ? py : b_ymax;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_cnt <= '0; y_cnt <= '0;
      acc_cnt <= '0; acc_xsum <= '0; acc_ysum <= '0;
      acc_xmin <= CMAX; acc_xmax <= '0; acc_ymin <= CMAX; acc_ymax <= '0;
      snap_vld <= 1'b0; snap_cnt <= '0; snap_xsum <= '0; snap_ysum <= '0;
      snap_xmin <= '0; snap_xmax <= '0; snap_ymin <= '0; snap_ymax <= '0;
      sync_error_count <= '0;
    end else begin
      snap_vld <= 1'b0;
      if (pixel_valid) begin
        if (early_sof && sync_error_count != 8'hFF) sync_error_count <= sync_error_count + 8'd1;
        x_cnt <= (px == X_LAST) ? '0 : px + COORD_WIDTH'(1);
        y_cnt <= (px != X_LAST) ? py : (py == Y_LAST) ? '0 : py + COORD_WIDTH'(1);
        if (last_px) begin
          snap_vld  <= 1'b1;
          snap_cnt  <= nxt_cnt;  snap_xsum <= nxt_xsum; snap_ysum <= nxt_ysum;
          snap_xmin <= nxt_xmin; snap_xmax <= nxt_xmax;
          snap_ymin <= nxt_ymin; snap_ymax <= nxt_ymax;
          acc_cnt  <= '0; acc_xsum <= '0; acc_ysum <= '0;
          acc_xmin <= CMAX; acc_xmax <= '0; acc_ymin <= CMAX; acc_ymax <= '0;
        end else begin
          acc_cnt  <= nxt_cnt;  acc_xsum <= nxt_xsum; acc_ysum <= nxt_ysum;
          acc_xmin <= nxt_xmin; acc_xmax <= nxt_xmax;
          acc_ymin <= nxt_ymin; acc_ymax <= nxt_ymax;
        end
      end
    end
  end

  logic [1:0]             state;
  logic [DCW-1:0]         div_cnt;
  logic [COUNT_WIDTH-1:0] divisor, x_rem, y_rem, x_rem_n, y_rem_n;
  logic [SUM_WIDTH-1:0]   x_quo, y_quo, x_quo_n, y_quo_n;
  logic [COUNT_WIDTH:0]   x_trial, y_trial, x_diff, y_diff;
  logic                   x_ge, y_ge, last_iter, snap_found, take, drop_evt;

  // Restoring divide: quotient bits shift into the low end as dividend bits leave the top.
  always_comb begin
    x_trial    = {x_rem, x_quo[SUM_WIDTH-1]};
    y_trial    = {y_rem, y_quo[SUM_WIDTH-1]};
    x_diff     = x_trial - {1'b0, divisor};
    y_diff     = y_trial - {1'b0, divisor};
    x_ge       = x_trial >= {1'b0, divisor};
    y_ge       = y_trial >= {1'b0, divisor};
    x_rem_n    = x_ge ? x_diff[COUNT_WIDTH-1:0] : x_trial[COUNT_WIDTH-1:0];
    y_rem_n    = y_ge ? y_diff[COUNT_WIDTH-1:0] : y_trial[COUNT_WIDTH-1:0];
    x_quo_n    = {x_quo[SUM_WIDTH-2:0], x_ge};
    y_quo_n    = {y_quo[SUM_WIDTH-2:0], y_ge};
    last_iter  = div_cnt == DCW'(SUM_WIDTH - 1);
    snap_found = snap_cnt >= COUNT_WIDTH'(MIN_PIXELS);
    take       = snap_vld && (state == IDLE || (state == HOLD && out_ready));
    drop_evt   = snap_vld && !take;
  end

  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE; div_cnt <= '0; divisor <= '0;
      x_rem <= '0; y_rem <= '0; x_quo <= '0; y_quo <= '0;
      object_found <= 1'b0; x_position <= '0; y_position <= '0; pixel_count <= '0;
      bbox_x_min <= '0; bbox_x_max <= '0; bbox_y_min <= '0; bbox_y_max <= '0;
      drop_count <= '0;
    end else begin
      if (drop_evt && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (take) begin
        pixel_count <= snap_cnt;
        if (snap_found) begin
          state <= DIVIDE; object_found <= 1'b1;
          bbox_x_min <= snap_xmin; bbox_x_max <= snap_xmax;
          bbox_y_min <= snap_ymin; bbox_y_max <= snap_ymax;
          divisor <= snap_cnt; x_quo <= snap_xsum; y_quo <= snap_ysum;
          x_rem <= '0; y_rem <= '0; div_cnt <= '0;
        end else begin
          state <= HOLD; object_found <= 1'b0;
          x_position <= '0; y_position <= '0;
          bbox_x_min <= '0; bbox_x_max <= '0; bbox_y_min <= '0; bbox_y_max <= '0;
        end
      end else begin
        case (state)
          DIVIDE: begin
            x_rem <= x_rem_n; y_rem <= y_rem_n;
            x_quo <= x_quo_n; y_quo <= y_quo_n;
            div_cnt <= div_cnt + DCW'(1);
            if (last_iter) begin
              state      <= HOLD;
              x_position <= x_quo_n[COORD_WIDTH-1:0];
              y_position <= y_quo_n[COORD_WIDTH-1:0];
            end
          end
          HOLD:    if (out_ready) state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker on an 8x6 frame with a frame-level reference model.
module tb_centroid_tracker;
  localparam int W = 8, H = 6, MINP = 4, SW = 16, CW = 4, NW = 7, PW = 10;

  logic clk = 1'b0, aresetn = 1'b0, pixel_valid = 1'b0, sof = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] pixel_data = '0, threshold = '0;
  logic out_valid, object_found;
  logic [CW-1:0] x_position, y_position, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [NW-1:0] pixel_count;
  logic [7:0] drop_count, sync_error_count;

  always #5 clk = ~clk;

  centroid_tracker #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COLOR_WIDTH(PW), .COORD_WIDTH(CW),
                     .COUNT_WIDTH(NW), .SUM_WIDTH(SW), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .aresetn(aresetn), .pixel_valid(pixel_valid), .sof(sof),
    .pixel_data(pixel_data), .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
    .object_found(object_found), .x_position(x_position), .y_position(y_position),
    .pixel_count(pixel_count), .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max), .drop_count(drop_count),
    .sync_error_count(sync_error_count));

  typedef struct { bit found; int cnt, x, y, x0, x1, y0, y1; } res_t;

  int n_cmp = 0, n_err = 0;
  int img[H][W];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole-frame arithmetic plus the result channel's occupancy rules.
  int mx, my, m_cnt, m_sx, m_sy, m_x0, m_x1, m_y0, m_y1, m_sync, m_drop, avail, n_xfer;
  int cyc = 0;
  bit have, ev_pend, exp_valid, xfer;
  res_t cur, ev_res;

  function automatic void m_clear();
    m_cnt = 0; m_sx = 0; m_sy = 0; m_x0 = W; m_x1 = -1; m_y0 = H; m_y1 = -1;
  endfunction

  initial begin
    mx = 0; my = 0; m_clear(); m_sync = 0; m_drop = 0; n_xfer = 0;
    have = 0; ev_pend = 0; exp_valid = 0; avail = 0;
    forever begin
      @(posedge clk);
      if (!aresetn) begin
        mx = 0; my = 0; m_clear(); m_sync = 0; m_drop = 0;
        have = 0; ev_pend = 0; exp_valid = 0;
      end else begin
        cyc++;
        xfer = exp_valid && out_ready;
        if (xfer) n_xfer++;
        if (ev_pend) begin
          if (!have || xfer) begin
            have = 1; cur = ev_res; avail = cyc + (ev_res.found ? SW : 0);
          end else if (m_drop < 255) m_drop++;
          ev_pend = 0;
        end else if (xfer) have = 0;
        if (pixel_valid) begin
          if (sof && (mx != 0 || my != 0)) begin
            mx = 0; my = 0; m_clear();
            if (m_sync < 255) m_sync++;
          end
          if (pixel_data >= threshold) begin
            m_cnt++; m_sx += mx; m_sy += my;
            if (mx < m_x0) m_x0 = mx;
            if (mx > m_x1) m_x1 = mx;
            if (my < m_y0) m_y0 = my;
            if (my > m_y1) m_y1 = my;
          end
          if (mx == W-1 && my == H-1) begin
            ev_res.cnt = m_cnt;
            ev_res.found = (m_cnt >= MINP);
            if (ev_res.found) begin
              ev_res.x = m_sx / m_cnt; ev_res.y = m_sy / m_cnt;
              ev_res.x0 = m_x0; ev_res.x1 = m_x1; ev_res.y0 = m_y0; ev_res.y1 = m_y1;
            end else begin
              ev_res.x = 0; ev_res.y = 0; ev_res.x0 = 0; ev_res.x1 = 0; ev_res.y0 = 0; ev_res.y1 = 0;
            end
            ev_pend = 1; m_clear();
          end
          mx++;
          if (mx == W) begin mx = 0; my++; if (my == H) my = 0; end
        end
        exp_valid = have && (cyc >= avail);
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (aresetn && cyc > 0) begin
        chk("m.out_valid", int'(out_valid), int'(exp_valid));
        if (exp_valid) begin
          chk("m.found", int'(object_found), int'(cur.found));
          chk("m.count", int'(pixel_count), cur.cnt);
          chk("m.x", int'(x_position), cur.x);
          chk("m.y", int'(y_position), cur.y);
          chk("m.bx0", int'(bbox_x_min), cur.x0);
          chk("m.bx1", int'(bbox_x_max), cur.x1);
          chk("m.by0", int'(bbox_y_min), cur.y0);
          chk("m.by1", int'(bbox_y_max), cur.y1);
        end
        chk("m.drop", int'(drop_count), m_drop);
        chk("m.sync", int'(sync_error_count), m_sync);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void set_block(input int x0, input int x1, input int y0, input int y1, input int v);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        img[yy][xx] = (xx >= x0 && xx <= x1 && yy >= y0 && yy <= y1) ? v : 0;
  endfunction

  task automatic send_px(input int d, input bit s, input int gap);
    while ($urandom_range(0, 99) < gap) @(negedge clk);
    pixel_valid = 1'b1; pixel_data = PW'(d); sof = s;
    @(negedge clk);
    pixel_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        send_px(img[yy][xx], (xx == 0 && yy == 0), gap);
  endtask

  // Called at the negedge right after the last pixel was accepted; out_ready is held low.
  task automatic get_result(input string tag, input bit f, input int c, input int x, input int y,
                            input int x0, input int x1, input int y0, input int y1, input int lat);
    int k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    chk({tag, ".valid"}, int'(out_valid), 1);
    if (lat >= 0) chk({tag, ".latency"}, k, lat);
    chk({tag, ".found"}, int'(object_found), int'(f));
    chk({tag, ".count"}, int'(pixel_count), c);
    chk({tag, ".x"}, int'(x_position), x);
    chk({tag, ".y"}, int'(y_position), y);
    chk({tag, ".bx0"}, int'(bbox_x_min), x0);
    chk({tag, ".bx1"}, int'(bbox_x_max), x1);
    chk({tag, ".by0"}, int'(bbox_y_min), y0);
    chk({tag, ".by1"}, int'(bbox_y_max), y1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic set_thresh_img();
    set_block(0, -1, 0, -1, 0);
    for (int xx = 2; xx <= 5; xx++) begin
      img[1][xx] = 512; img[2][xx] = 511; img[3][xx] = 1023;
    end
  endtask

  initial begin
    int x_before;
    threshold = 10'd512;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.count", int'(pixel_count), 0);
    chk("rst.bx0", int'(bbox_x_min), 0);
    chk("rst.drop", int'(drop_count), 0);
    chk("rst.sync", int'(sync_error_count), 0);
    #1 aresetn = 1'b1;
    @(negedge clk);

    // Found object: 4x3 block
    set_block(2, 5, 1, 3, 600);
    send_frame(0);
    get_result("found", 1, 12, 3, 2, 2, 5, 1, 3, SW + 1);

    // Below minimum: 3 scattered pixels
    set_block(0, -1, 0, -1, 0);
    img[0][0] = 600; img[5][7] = 600; img[2][4] = 600;
    send_frame(0);
    get_result("below", 0, 3, 0, 0, 0, 0, 0, 0, 1);

    // Threshold boundary: 512 counts, 511 does not
    set_thresh_img();
    send_frame(0);
    get_result("thresh", 1, 8, 3, 2, 2, 5, 1, 3, SW + 1);

    // Early sof at (3,2): 19 object pixels of a partial frame are discarded
    for (int i = 0; i < 2*W + 3; i++) send_px(1000, i == 0, 0);
    set_block(2, 5, 1, 3, 600);
    send_frame(0);
    get_result("resync", 1, 12, 3, 2, 2, 5, 1, 3, SW + 1);
    chk("resync.sync", int'(sync_error_count), 1);

    // Backpressure across two further frames
    send_frame(0);
    set_block(0, -1, 0, -1, 0);
    send_frame(0);
    set_block(2, 5, 1, 3, 600);
    send_frame(0);
    repeat (5) @(negedge clk);
    chk("bp.valid", int'(out_valid), 1);
    chk("bp.count", int'(pixel_count), 12);
    chk("bp.x", int'(x_position), 3);
    chk("bp.drop", int'(drop_count), 2);
    x_before = n_xfer;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    out_ready = 1'b0;
    chk("bp.transfers", n_xfer - x_before, 1);

    // Gapped input gives the same results
    send_frame(30);
    get_result("gap.found", 1, 12, 3, 2, 2, 5, 1, 3, -1);
    set_thresh_img();
    send_frame(40);
    get_result("gap.thresh", 1, 8, 3, 2, 2, 5, 1, 3, -1);

    // Reset during divide
    set_block(2, 5, 1, 3, 600);
    send_frame(0);
    repeat (5) @(negedge clk);
    #1 aresetn = 1'b0;
    #1;
    chk("rstdiv.valid", int'(out_valid), 0);
    chk("rstdiv.count", int'(pixel_count), 0);
    chk("rstdiv.found", int'(object_found), 0);
    chk("rstdiv.bx1", int'(bbox_x_max), 0);
    chk("rstdiv.drop", int'(drop_count), 0);
    chk("rstdiv.sync", int'(sync_error_count), 0);
    repeat (2) @(negedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    set_thresh_img();
    send_frame(0);
    get_result("postrst", 1, 8, 3, 2, 2, 5, 1, 3, SW + 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
